// File: rtl/snes_pkg.sv
// Shared SNES controller definitions: FSM state encoding, frame width, button bit positions.
// Button indices follow the order in which a standard pad shifts its bits out.
package snes_pkg;

  localparam int SNES_NUM_BITS = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    CLK_LOW  = 3'd2,
    CLK_HIGH = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_poller_if.sv
// Bundle between the poller, the pad wires and the button consumer.
// master = poller side; slave = pad plus consumer side.
interface snes_poller_if
  import snes_pkg::*;
#(
  parameter int N = SNES_NUM_BITS
);
  logic         poll_now;
  logic         serial_in;
  logic         snes_latch;
  logic         snes_clk;
  logic [N-1:0] buttons;
  logic         valid;
  logic         busy;

  modport master (
    input  poll_now, serial_in,
    output snes_latch, snes_clk, buttons, valid, busy
  );

  modport slave (
    output poll_now, serial_in,
    input  snes_latch, snes_clk, buttons, valid, busy
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with selectable reset level; 2-cycle latency, no backpressure.
// Also used on the PS/2 clock and data lines.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/snes_poller.sv
// SNES pad master: latch pulse, NUM_BITS serial clocks, active-high button word out.
// Frame = 34*HALF_PERIOD+1 cycles; poll requests during a frame are dropped, no backpressure.
module snes_poller
  import snes_pkg::*;
#(
  parameter int HALF_PERIOD   = 12,
  parameter int POLL_INTERVAL = 34667,
  parameter int NUM_BITS      = SNES_NUM_BITS
) (
  input  logic          clk,
  input  logic          reset,
  snes_poller_if.master bus
);
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int IW = $clog2(POLL_INTERVAL);
  localparam int BW = $clog2(NUM_BITS);

  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [IW-1:0] IVL_LAST   = IW'(POLL_INTERVAL - 1);
  localparam logic [BW-1:0] IDX_LAST   = BW'(NUM_BITS - 1);

  state_t              state, state_n;
  logic [PW-1:0]       phase;
  logic [IW-1:0]       ivl;
  logic [BW-1:0]       idx;
  logic [NUM_BITS-1:0] sreg;
  logic                sin_sync;
  logic                start;
  logic                phase_end;

  // Line idles high, so the synchronizer resets to 1 to avoid a fake press.
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.serial_in),
    .q     (sin_sync)
  );

  always_comb begin
    start     = (state == IDLE) && (bus.poll_now || (ivl == IVL_LAST));
    phase_end = (state == LATCH) ? (phase == LATCH_LAST) : (phase == HALF_LAST);
    state_n   = state;
    case (state)
      IDLE:     if (start) state_n = LATCH;
      LATCH:    if (phase_end) state_n = CLK_LOW;
      CLK_LOW:  if (phase_end) state_n = CLK_HIGH;
      CLK_HIGH: if (phase_end) state_n = (idx == IDX_LAST) ? DONE : CLK_LOW;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      phase          <= '0;
      ivl            <= '0;
      idx            <= '0;
      sreg           <= '0;
      bus.snes_latch <= 1'b0;
      bus.snes_clk   <= 1'b1;
      bus.buttons    <= '0;
      bus.valid      <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state <= state_n;

      if (state_n != state || state == IDLE) phase <= '0;
      else                                   phase <= phase + 1'b1;

      // Keeps counting through a frame so the poll rate is start-to-start.
      if (start)                ivl <= '0;
      else if (ivl != IVL_LAST) ivl <= ivl + 1'b1;

      if (state == LATCH)
        idx <= '0;
      else if (state == CLK_HIGH && phase_end && idx != IDX_LAST)
        idx <= idx + 1'b1;

      if (state == LATCH)
        sreg <= '0;
      else if (state == CLK_LOW && phase_end)
        sreg[idx] <= ~sin_sync;

      // Outputs are registered from the next state so they line up with it.
      bus.snes_latch <= (state_n == LATCH);
      bus.snes_clk   <= (state_n != CLK_LOW);
      bus.busy       <= (state_n != IDLE);
      bus.valid      <= (state_n == DONE);
      if (state_n == DONE) bus.buttons <= sreg;
    end
  end
endmodule

// File: tb/tb_snes_poller.sv
// Directed bench for snes_poller with a behavioural pad model on the serial wires.
// Uses HALF_PERIOD=2 and POLL_INTERVAL=200, giving a 69-cycle frame.
module tb_snes_poller;
  import snes_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  logic [15:0] pad_word;
  logic [15:0] pad_sr;
  logic        stuck_low;
  logic        clk_q;

  int latch_cyc, busy_cyc, valid_cyc, low_starts, low_run, bad_pulse;

  snes_poller_if #(.N(16)) bus ();

  snes_poller #(
    .HALF_PERIOD   (2),
    .POLL_INTERVAL (200),
    .NUM_BITS      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.serial_in = stuck_low ? 1'b0 : pad_sr[0];

  // Pad model (loads on latch, shifts on rising snes_clk) plus frame monitors.
  always @(negedge clk) begin
    if (bus.snes_latch) latch_cyc++;
    if (bus.busy)       busy_cyc++;
    if (bus.valid)      valid_cyc++;
    if (!bus.snes_clk && clk_q) low_starts++;
    if (!bus.snes_clk) low_run++;
    else if (low_run != 0) begin
      if (low_run != 2) bad_pulse++;
      low_run = 0;
    end
    if (bus.snes_latch)                pad_sr = pad_word;
    else if (bus.snes_clk && !clk_q)   pad_sr = {1'b1, pad_sr[15:1]};
    clk_q = bus.snes_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    latch_cyc  = 0;
    busy_cyc   = 0;
    valid_cyc  = 0;
    low_starts = 0;
    low_run    = 0;
    bad_pulse  = 0;
  endtask

  task automatic poll();
    @(posedge clk); #1;
    clear_mon();
    bus.poll_now = 1'b1;
    @(posedge clk); #1;
    bus.poll_now = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 150; i++) begin
      if (bus.valid) break;
      @(posedge clk); #1;
    end
    chk({tag, "_valid_seen"}, 32'(bus.valid), 32'd1);
  endtask

  initial begin
    int  n;
    bit  seen_idle;
    n_assert     = 0;
    n_fail       = 0;
    pad_word     = 16'hFFFF;
    pad_sr       = 16'hFFFF;
    stuck_low    = 1'b0;
    clk_q        = 1'b1;
    bus.poll_now = 1'b0;
    clear_mon();

    // Reset and first automatic frame
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hold_clk", 32'(bus.snes_clk), 32'd1);
    reset = 1'b1;
    chk("rst_latch",   32'(bus.snes_latch), 32'd0);
    chk("rst_clk",     32'(bus.snes_clk),   32'd1);
    chk("rst_buttons", 32'(bus.buttons),    32'h0000);
    chk("rst_valid",   32'(bus.valid),      32'd0);
    chk("rst_busy",    32'(bus.busy),       32'd0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.snes_latch) break;
    end
    chk("auto_first_start", 32'(n), 32'd200);
    wait_valid("auto_first");
    chk("all_high_buttons", 32'(bus.buttons), 32'h0000);

    // Single frame with mixed pattern
    pad_word = 16'b1111_0101_1100_0011;
    poll();
    chk("single_latch_now", 32'(bus.snes_latch), 32'd1);
    wait_valid("single");
    chk("single_buttons", 32'(bus.buttons), 32'h0A3C);
    repeat (3) @(posedge clk);
    #1;
    chk("single_latch_cyc",  32'(latch_cyc),  32'd4);
    chk("single_low_pulses", 32'(low_starts), 32'd16);
    chk("single_bad_pulse",  32'(bad_pulse),  32'd0);
    chk("single_valid_cyc",  32'(valid_cyc),  32'd1);
    chk("single_busy_cyc",   32'(busy_cyc),   32'd69);
    chk("single_hold",       32'(bus.buttons), 32'h0A3C);

    // Only A pressed
    pad_word = ~(16'h0001 << BTN_A);
    poll();
    wait_valid("a_only");
    chk("a_only_buttons", 32'(bus.buttons), 32'h0100);

    // Line stuck low
    stuck_low = 1'b1;
    poll();
    wait_valid("stuck");
    chk("stuck_buttons", 32'(bus.buttons), 32'hFFFF);
    stuck_low = 1'b0;

    // poll_now during a frame is dropped; auto poll still counts from the original start
    pad_word = ~16'h1234;
    poll();
    n = 0;
    repeat (9) begin
      @(posedge clk); #1;
      n++;
    end
    bus.poll_now = 1'b1;
    @(posedge clk); #1;
    n++;
    bus.poll_now = 1'b0;
    chk("overlap_busy", 32'(bus.busy), 32'd1);
    seen_idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      n++;
      if (!bus.busy) seen_idle = 1'b1;
      else if (seen_idle && bus.snes_latch) break;
    end
    chk("overlap_next_start", 32'(n),         32'd200);
    chk("overlap_valid_cyc",  32'(valid_cyc), 32'd1);
    chk("overlap_busy_cyc",   32'(busy_cyc),  32'd69);
    chk("overlap_buttons",    32'(bus.buttons), 32'h1234);
    wait_valid("overlap_auto");
    chk("overlap_auto_buttons", 32'(bus.buttons), 32'h1234);

    // Reset during the 7th clock-low pulse
    pad_word = ~16'h00FF;
    poll();
    for (int i = 0; i < 100; i++) begin
      if (low_starts == 7 && !bus.snes_clk) break;
      @(posedge clk); #1;
    end
    chk("midrst_reached", 32'(low_starts), 32'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_latch",   32'(bus.snes_latch), 32'd0);
    chk("midrst_clk",     32'(bus.snes_clk),   32'd1);
    chk("midrst_buttons", 32'(bus.buttons),    32'h0000);
    chk("midrst_valid",   32'(bus.valid),      32'd0);
    chk("midrst_busy",    32'(bus.busy),       32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_hold_buttons", 32'(bus.buttons), 32'h0000);
    reset = 1'b1;
    pad_word = ~16'h5AA5;
    poll();
    wait_valid("post_rst");
    chk("post_rst_buttons", 32'(bus.buttons), 32'h5AA5);

    // Back-to-back frames
    pad_word = ~16'h0001;
    poll();
    wait_valid("b2b_first");
    chk("b2b_first_buttons", 32'(bus.buttons), 32'h0001);
    pad_word = ~16'h8000;
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
    bus.poll_now = 1'b1;
    @(posedge clk); #1;
    bus.poll_now = 1'b0;
    chk("b2b_latch_next", 32'(bus.snes_latch), 32'd1);
    wait_valid("b2b_second");
    chk("b2b_second_buttons", 32'(bus.buttons), 32'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
